// File: rtl/cordic_pipe_reg_if.sv
// Valid/ready stream bundle for the elastic CORDIC pipeline register.
// The slave modport is the pipeline's view; the master modport is the surrounding datapath.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

interface cordic_pipe_reg_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CH*WORD_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*WORD_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]             occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/cordic_pipe_reg.sv
// Elastic DEPTH-stage register for NUM_CH signed CORDIC channels with valid/ready,
// synchronous flush and a registered occupancy count. Data passes through untouched.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module cordic_pipe_reg #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 2
) (
  input logic              clk,
  input logic              rst,
  cordic_pipe_reg_if.slave bus
);
  localparam int DW    = NUM_CH * WORD_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [DW-1:0]    r_d [DEPTH];
  logic [CNT_W-1:0] r_occ;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_src_v;
  logic [DW-1:0]    w_src_d [DEPTH];
  logic [DEPTH-1:0] w_go;
  logic [DEPTH-1:0] w_v_nxt;
  logic [CNT_W-1:0] w_occ_nxt;

  // A stage can take a word if it, or any stage downstream of it, is empty, or the
  // output is being popped; written flat so no ready bit depends on another.
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    assign w_rdy[s] = bus.out_ready | ~(&r_v[DEPTH-1:s]);
    if (s == 0) begin : g_head
      assign w_src_v[s] = bus.in_valid;
      assign w_src_d[s] = bus.in_data;
    end else begin : g_body
      assign w_src_v[s] = r_v[s-1];
      assign w_src_d[s] = r_d[s-1];
    end
    assign w_go[s] = w_src_v[s] & w_rdy[s] & ~bus.flush;
  end

  // NOTE: every variable gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    w_v_nxt   = r_v;
    w_occ_nxt = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (bus.flush) begin
        w_v_nxt[s] = 1'b0;
      end else if (w_rdy[s]) begin
        w_v_nxt[s] = w_src_v[s];
      end
      w_occ_nxt = w_occ_nxt + CNT_W'(w_v_nxt[s]);
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end

  // NOTE: the data stages are reset too, because out_data must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) r_d[s] <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        if (w_go[s]) r_d[s] <= w_src_d[s];
      end
    end
  end

  assign bus.in_ready  = w_rdy[0] & ~bus.flush;
  assign bus.out_valid = r_v[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = r_d[DEPTH-1];
  assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_cordic_pipe_reg.sv
// Bench for cordic_pipe_reg: DEPTH=3 and DEPTH=4 instances share one stimulus stream and
// are compared against a queue model in which a head word is visible once it is DEPTH-1 edges old.
module tb_cordic_pipe_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [47:0] in_data = '0;

  int checks = 0;
  int errors = 0;

  cordic_pipe_reg_if #(.WORD_WIDTH(16), .NUM_CH(3), .DEPTH(3)) b3 ();
  cordic_pipe_reg_if #(.WORD_WIDTH(16), .NUM_CH(3), .DEPTH(4)) b4 ();

  assign b3.flush = flush;  assign b3.in_valid = in_valid;
  assign b3.in_data = in_data;  assign b3.out_ready = out_ready;
  assign b4.flush = flush;  assign b4.in_valid = in_valid;
  assign b4.in_data = in_data;  assign b4.out_ready = out_ready;

  cordic_pipe_reg #(.WORD_WIDTH(16), .NUM_CH(3), .DEPTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  cordic_pipe_reg #(.WORD_WIDTH(16), .NUM_CH(3), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  // Reference model: one FIFO per instance, each entry stamped with its acceptance edge.
  typedef struct { logic [47:0] d; int t; } item_t;
  item_t mbuf [2][8];
  int    mhead [2] = '{0, 0};
  int    mcnt  [2] = '{0, 0};
  int    cyc = 0;

  typedef struct {
    logic        iv;
    logic [47:0] d;
    logic        e_ir;
    logic        e_ov;
    int          e_occ;
    logic [47:0] e_od;
  } vec_t;
  vec_t tbl [9];

  function automatic int dep(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic logic m_ir(input int i);
    return !flush && ((mcnt[i] < dep(i)) || out_ready);
  endfunction

  function automatic logic m_ov(input int i);
    return !flush && (mcnt[i] > 0) && ((cyc - mbuf[i][mhead[i]].t) >= dep(i) - 1);
  endfunction

  function automatic logic [47:0] pk(input int x, input int y, input int z);
    return {z[15:0], y[15:0], x[15:0]};
  endfunction

  function automatic logic [47:0] sw(input int k);
    return pk(32767 + k, -1 + k, 5 + k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [47:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]  = 0;
      mhead[i] = 0;
    end
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic        acc [2];
    logic        pop [2];
    logic        fl;
    logic [47:0] d;
    fl = flush;
    d  = in_data;
    for (int i = 0; i < 2; i++) begin
      acc[i] = in_valid & m_ir(i);
      pop[i] = out_ready & m_ov(i);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        mcnt[i] = 0;
      end else begin
        if (pop[i]) begin
          mhead[i] = (mhead[i] + 1) % 8;
          mcnt[i]--;
        end
        if (acc[i]) begin
          mbuf[i][(mhead[i] + mcnt[i]) % 8] = '{d: d, t: cyc};
          mcnt[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic model_cmp();
    logic ov3, ov4;
    ov3 = m_ov(0);
    ov4 = m_ov(1);
    check("rnd3_in_ready",  64'(b3.in_ready),  64'(m_ir(0)));
    check("rnd3_out_valid", 64'(b3.out_valid), 64'(ov3));
    check("rnd3_occupancy", 64'(b3.occupancy), 64'(mcnt[0]));
    if (ov3) check("rnd3_out_data", 64'(b3.out_data), 64'(mbuf[0][mhead[0]].d));
    check("rnd4_in_ready",  64'(b4.in_ready),  64'(m_ir(1)));
    check("rnd4_out_valid", 64'(b4.out_valid), 64'(ov4));
    check("rnd4_occupancy", 64'(b4.occupancy), 64'(mcnt[1]));
    if (ov4) check("rnd4_out_data", 64'(b4.out_data), 64'(mbuf[1][mhead[1]].d));
  endtask

  initial begin
    logic [47:0] exp_w [4];
    int k;

    // Streaming vectors: x starts at 32767 (wraps to -32768), y at -1, z at 5.
    for (int r = 0; r < 9; r++) begin
      tbl[r].iv    = (r < 6);
      tbl[r].d     = (r < 6) ? sw(r) : 48'h0;
      tbl[r].e_ir  = 1'b1;
      tbl[r].e_ov  = (r >= 3);
      tbl[r].e_occ = (r < 3) ? r : ((r <= 6) ? 3 : 9 - r);
      tbl[r].e_od  = (r >= 3) ? sw(r - 3) : 48'h0;
    end

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(b3.out_valid), 64'(0));
    check("rst_occupancy", 64'(b3.occupancy), 64'(0));
    check("rst_out_data",  64'(b3.out_data),  64'(0));
    check("rst_in_ready",  64'(b3.in_ready),  64'(1));
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // Streaming with out_ready held high
    for (int r = 0; r < 9; r++) begin
      set_in(tbl[r].iv, tbl[r].d, 1'b1, 1'b0);
      #1;
      check("stream_in_ready",  64'(b3.in_ready),  64'(tbl[r].e_ir));
      check("stream_out_valid", 64'(b3.out_valid), 64'(tbl[r].e_ov));
      check("stream_occupancy", 64'(b3.occupancy), 64'(tbl[r].e_occ));
      if (tbl[r].e_ov) check("stream_out_data", 64'(b3.out_data), 64'(tbl[r].e_od));
      tick();
    end

    // Asynchronous reset with two stages valid
    set_in(1'b1, pk(1, 2, 3), 1'b0, 1'b0);  tick();
    set_in(1'b1, pk(4, 5, 6), 1'b0, 1'b0);  tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);
    #1 check("pre_rst_occupancy", 64'(b3.occupancy), 64'(2));
    #2 rst = 1'b1;
    model_clear();
    #1;
    check("async_rst_out_valid", 64'(b3.out_valid), 64'(0));
    check("async_rst_occupancy", 64'(b3.occupancy), 64'(0));
    check("async_rst_out_data",  64'(b3.out_data),  64'(0));
    check("async_rst_in_ready",  64'(b3.in_ready),  64'(1));
    @(negedge clk);
    rst = 1'b0;

    // Back-pressure: five words offered against a stalled output
    k = 1;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, pk(1000 + k, -1000 - k, k), 1'b0, 1'b0);
      #1 check("bp_in_ready", 64'(b3.in_ready), 64'(c < 3));
      if (c < 3) k++;
      tick();
    end
    #1;
    check("bp_full_occupancy", 64'(b3.occupancy), 64'(3));
    check("bp_full_in_ready",  64'(b3.in_ready),  64'(0));
    for (int j = 0; j < 5; j++) begin
      set_in(k <= 5, pk(1000 + k, -1000 - k, k), 1'b1, 1'b0);
      #1;
      check("bp_out_valid", 64'(b3.out_valid), 64'(1));
      check("bp_out_data",  64'(b3.out_data),  64'(pk(1001 + j, -1001 - j, j + 1)));
      check("bp_occupancy", 64'(b3.occupancy), 64'((j < 3) ? 3 : 5 - j));
      if (k <= 5) begin
        check("bp_release_in_ready", 64'(b3.in_ready), 64'(1));
        k++;
      end
      tick();
    end

    // Simultaneous push and pop while full
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, pk(2000 + c, -c, c), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 48'h0, 1'b0, 1'b0);
    #1 check("pp_fill_occupancy", 64'(b3.occupancy), 64'(3));
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, pk(2003 + c, -3 - c, 3 + c), 1'b1, 1'b0);
      #1;
      check("pp_in_ready",  64'(b3.in_ready),  64'(1));
      check("pp_occupancy", 64'(b3.occupancy), 64'(3));
      check("pp_out_data",  64'(b3.out_data),  64'(pk(2000 + c, -c, c)));
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 48'h0, 1'b1, 1'b0);
      #1;
      check("pp_drain_valid", 64'(b3.out_valid), 64'(1));
      check("pp_drain_data",  64'(b3.out_data),  64'(pk(2004 + c, -4 - c, 4 + c)));
      tick();
    end

    // Flush with two words held and both ports active
    set_in(1'b1, pk(7, 7, 7), 1'b0, 1'b0);  tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);        tick();
    set_in(1'b1, pk(8, 8, 8), 1'b0, 1'b0);  tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);
    #1;
    check("fl_pre_occupancy", 64'(b3.occupancy), 64'(2));
    check("fl_pre_out_valid", 64'(b3.out_valid), 64'(1));
    set_in(1'b1, pk(9, 9, 9), 1'b1, 1'b1);
    #1;
    check("fl_in_ready",  64'(b3.in_ready),  64'(0));
    check("fl_out_valid", 64'(b3.out_valid), 64'(0));
    tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);
    #1;
    check("fl_post_occupancy", 64'(b3.occupancy), 64'(0));
    check("fl_post_out_valid", 64'(b3.out_valid), 64'(0));

    // Bubble collapse on the DEPTH=4 instance
    exp_w = '{pk(10, -10, 1), pk(20, -20, 2), pk(30, -30, 3), pk(40, -40, 4)};
    set_in(1'b1, exp_w[0], 1'b0, 1'b0);  tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);     tick();
    set_in(1'b1, exp_w[1], 1'b0, 1'b0);  tick();
    set_in(1'b0, 48'h0, 1'b0, 1'b0);     tick();
    set_in(1'b1, exp_w[2], 1'b0, 1'b0);
    #1;
    check("bub_occupancy", 64'(b4.occupancy), 64'(2));
    check("bub_in_ready_c", 64'(b4.in_ready), 64'(1));
    tick();
    set_in(1'b1, exp_w[3], 1'b0, 1'b0);
    #1 check("bub_in_ready_d", 64'(b4.in_ready), 64'(1));
    tick();
    set_in(1'b1, pk(50, -50, 5), 1'b0, 1'b0);
    #1;
    check("bub_full_occupancy", 64'(b4.occupancy), 64'(4));
    check("bub_full_in_ready",  64'(b4.in_ready),  64'(0));
    for (int j = 0; j < 4; j++) begin
      set_in(1'b0, 48'h0, 1'b1, 1'b0);
      #1;
      check("bub_out_valid", 64'(b4.out_valid), 64'(1));
      check("bub_out_data",  64'(b4.out_data),  64'(exp_w[j]));
      tick();
    end

    // Randomised traffic on both depths against the model
    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 9) < 7, {16'($urandom()), $urandom()},
             $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      #1 model_cmp();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
